// File: rtl/mem_port_if.sv
// Bus-side handshake and data signals of mem_port.
// The err signal exists only when MEM_PORT_BOUNDS_CHECK_EN is defined.
interface mem_port_if #(
  parameter int unsigned DATA_W = 32
);
  logic              clear;
  logic [DATA_W-1:0] BusMuxOut;
  logic              MARin;
  logic              MDRin;
  logic              read;
  logic              write;
  logic              start;
  logic [DATA_W-1:0] BusMuxInMDR;
  logic              busy;
  logic              done;
`ifdef MEM_PORT_BOUNDS_CHECK_EN
  logic              err;

  modport master (output clear, BusMuxOut, MARin, MDRin, read, write, start,
                  input  BusMuxInMDR, busy, done, err);
  modport slave  (input  clear, BusMuxOut, MARin, MDRin, read, write, start,
                  output BusMuxInMDR, busy, done, err);
`else
  modport master (output clear, BusMuxOut, MARin, MDRin, read, write, start,
                  input  BusMuxInMDR, busy, done);
  modport slave  (input  clear, BusMuxOut, MARin, MDRin, read, write, start,
                  output BusMuxInMDR, busy, done);
`endif
endinterface

// File: rtl/mem_port.sv
// MAR/MDR memory port with wait-stated single-word RAM accesses.
// Define MEM_PORT_BOUNDS_CHECK_EN to fault accesses with MAR >= DEPTH and drive err.
module mem_port #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned ADDR_W      = 9,
  parameter int unsigned DEPTH       = 512,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic       clock,
  input  logic       reset,
  mem_port_if.slave  bus
);

  localparam int unsigned CNT_W    = 4;
  localparam int unsigned RAM_AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam bit          FULL_MAP = (DEPTH == (32'd1 << ADDR_W));

  typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} stateT;

  stateT              state, stateNext;
  logic [CNT_W-1:0]   waitCnt, waitCntNext;
  logic               isWrite, isWriteNext;
  logic               busyNext, doneNext;
  logic [ADDR_W-1:0]  mar;
  logic [DATA_W-1:0]  mdr;
  logic [RAM_AW-1:0]  ramIdx;
  logic               inRange;
  logic               accessEn;

  logic [DATA_W-1:0]  ram [DEPTH];

  // Physical word index: address folded into the implemented range
  if (FULL_MAP) begin : gFullMap
    assign ramIdx = RAM_AW'(mar);
  end else begin : gFoldMap
    assign ramIdx = RAM_AW'(32'(mar) % DEPTH);
  end

`ifdef MEM_PORT_BOUNDS_CHECK_EN
  logic errNext;
  assign inRange = (32'(mar) < DEPTH);
`else
  assign inRange = 1'b1;
`endif

  assign accessEn        = (state == ACCESS) && !bus.clear && inRange;
  assign bus.BusMuxInMDR = mdr;

  // Next-state and registered-output decode
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    isWriteNext = isWrite;
    unique case (state)
      IDLE: begin
        if (bus.start && (bus.read ^ bus.write)) begin
          isWriteNext = bus.write;
          waitCntNext = '0;
          stateNext   = (WAIT_CYCLES == 0) ? ACCESS : WAIT;
        end
      end
      WAIT: begin
        if (waitCnt == CNT_W'(WAIT_CYCLES - 1)) stateNext = ACCESS;
        else waitCntNext = waitCnt + CNT_W'(1);
      end
      ACCESS:  stateNext = DONE;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
    if (bus.clear) begin
      stateNext   = IDLE;
      waitCntNext = '0;
    end
    busyNext = (stateNext != IDLE);
    doneNext = (stateNext == DONE);
`ifdef MEM_PORT_BOUNDS_CHECK_EN
    errNext  = (stateNext == DONE) && !inRange;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      waitCnt  <= '0;
      isWrite  <= 1'b0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
`ifdef MEM_PORT_BOUNDS_CHECK_EN
      bus.err  <= 1'b0;
`endif
    end else begin
      state    <= stateNext;
      waitCnt  <= waitCntNext;
      isWrite  <= isWriteNext;
      bus.busy <= busyNext;
      bus.done <= doneNext;
`ifdef MEM_PORT_BOUNDS_CHECK_EN
      bus.err  <= errNext;
`endif
    end
  end

  // MAR/MDR load only while idle so the access in flight stays frozen
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mar <= '0;
      mdr <= '0;
    end else if (bus.clear) begin
      mar <= '0;
      mdr <= '0;
    end else begin
      if (state == IDLE) begin
        if (bus.MARin) mar <= ADDR_W'(bus.BusMuxOut);
        if (bus.MDRin) mdr <= bus.BusMuxOut;
      end
      if (accessEn && !isWrite) mdr <= ram[ramIdx];
    end
  end

  // RAM array carries no reset so contents survive reset and clear
  always_ff @(posedge clock) begin
    if (accessEn && isWrite) ram[ramIdx] <= mdr;
  end

endmodule

// File: tb/tb_mem_port.sv
// Directed bench for mem_port: three instances (default, zero wait states,
// DEPTH=256) share one stimulus stream and are checked individually.
module tb_mem_port;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        clear, marIn, mdrIn, rd, wr, start;
  logic [31:0] busMuxOut;

  int nTests = 0;
  int nFail  = 0;
  int lat[3];
  int doneCnt[3];
  int busyCnt[3];
  logic err2;

  always #5 clock = ~clock;

  mem_port_if bus0 ();
  mem_port_if bus1 ();
  mem_port_if bus2 ();

  assign bus0.clear = clear; assign bus0.BusMuxOut = busMuxOut; assign bus0.MARin = marIn;
  assign bus0.MDRin = mdrIn; assign bus0.read = rd; assign bus0.write = wr; assign bus0.start = start;
  assign bus1.clear = clear; assign bus1.BusMuxOut = busMuxOut; assign bus1.MARin = marIn;
  assign bus1.MDRin = mdrIn; assign bus1.read = rd; assign bus1.write = wr; assign bus1.start = start;
  assign bus2.clear = clear; assign bus2.BusMuxOut = busMuxOut; assign bus2.MARin = marIn;
  assign bus2.MDRin = mdrIn; assign bus2.read = rd; assign bus2.write = wr; assign bus2.start = start;

  mem_port #(.WAIT_CYCLES(2))            dut0 (.clock(clock), .reset(reset), .bus(bus0.slave));
  mem_port #(.WAIT_CYCLES(0))            dut1 (.clock(clock), .reset(reset), .bus(bus1.slave));
  mem_port #(.DEPTH(256), .WAIT_CYCLES(2)) dut2 (.clock(clock), .reset(reset), .bus(bus2.slave));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic load(input logic m, input logic d, input logic [31:0] v);
    marIn = m; mdrIn = d; busMuxOut = v;
    cyc();
    marIn = 1'b0; mdrIn = 1'b0;
  endtask

  // Issue one start; hold keeps start high and loads MAR=0x1FF one cycle into the access
  task automatic runAccess(input logic r, input logic w, input logic hold);
    logic [2:0] dn, bz;
    rd = r; wr = w; start = 1'b1;
    for (int i = 0; i < 3; i++) begin lat[i] = 0; doneCnt[i] = 0; busyCnt[i] = 0; end
    err2 = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      cyc();
      if (hold && k == 1) begin
        marIn = 1'b1; busMuxOut = 32'h0000_01FF;
      end else begin
        start = 1'b0; marIn = 1'b0;
      end
      dn = {bus2.done, bus1.done, bus0.done};
      bz = {bus2.busy, bus1.busy, bus0.busy};
      for (int i = 0; i < 3; i++) begin
        if (dn[i]) begin doneCnt[i]++; if (lat[i] == 0) lat[i] = k; end
        if (bz[i]) busyCnt[i]++;
      end
`ifdef MEM_PORT_BOUNDS_CHECK_EN
      if (bus2.done) err2 = bus2.err;
`endif
    end
    rd = 1'b0; wr = 1'b0;
  endtask

  initial begin
    int n;
    clear = 0; marIn = 0; mdrIn = 0; rd = 0; wr = 0; start = 0; busMuxOut = '0;
    #2 reset = 1'b0;
    repeat (2) @(negedge clock);
    check("rst_busy", 64'(bus0.busy), 64'd0);
    check("rst_done", 64'(bus0.done), 64'd0);
    check("rst_mdr", 64'(bus0.BusMuxInMDR), 64'd0);
    reset = 1'b1;

    // Simultaneous MAR/MDR load, then write DEADBEEF to 0x005
    load(1, 1, 32'h8000_0005);
    check("dual_load_mdr", 64'(bus0.BusMuxInMDR), 64'h8000_0005);
    load(0, 1, 32'hDEAD_BEEF);
    runAccess(0, 1, 0);
    check("wr_lat0", 64'(lat[0]), 64'd4);
    check("wr_lat1", 64'(lat[1]), 64'd2);
    check("wr_lat2", 64'(lat[2]), 64'd4);
    check("wr_done_once", 64'(doneCnt[0]), 64'd1);

    // Read back after clearing MDR
    load(0, 1, 32'h0);
    check("mdr_zero", 64'(bus0.BusMuxInMDR), 64'd0);
    runAccess(1, 0, 0);
    check("rd_lat0", 64'(lat[0]), 64'd4);
    check("rd_lat1", 64'(lat[1]), 64'd2);
    check("rd_busy1", 64'(busyCnt[1]), 64'd2);
    check("rd_mdr0", 64'(bus0.BusMuxInMDR), 64'hDEAD_BEEF);
    check("rd_mdr1", 64'(bus1.BusMuxInMDR), 64'hDEAD_BEEF);
`ifdef MEM_PORT_BOUNDS_CHECK_EN
    check("rd_err_clean", 64'(err2), 64'd0);
`endif

    // start and MARin while busy are ignored
    load(0, 1, 32'h0);
    runAccess(1, 0, 1);
    check("busy_start_done0", 64'(doneCnt[0]), 64'd1);
    check("busy_start_done1", 64'(doneCnt[1]), 64'd1);
    check("busy_start_lat0", 64'(lat[0]), 64'd4);
    check("busy_mar_frozen", 64'(bus0.BusMuxInMDR), 64'hDEAD_BEEF);

    // Illegal read/write combinations never start
    load(0, 1, 32'h1234_5678);
    runAccess(1, 1, 0);
    check("both_hi_busy", 64'(busyCnt[0]), 64'd0);
    check("both_hi_done", 64'(doneCnt[0]), 64'd0);
    runAccess(0, 0, 0);
    check("both_lo_busy", 64'(busyCnt[1]), 64'd0);
    load(0, 1, 32'h0);
    runAccess(1, 0, 0);
    check("both_ram_kept", 64'(bus0.BusMuxInMDR), 64'hDEAD_BEEF);

    // Reset during WAIT of a write to 0x010
    load(1, 0, 32'h0000_0010);
    load(0, 1, 32'hCAFE_F00D);
    runAccess(0, 1, 0);
    load(0, 1, 32'h0BAD_F00D);
    wr = 1; start = 1;
    cyc();
    start = 0; wr = 0;
    check("pre_rst_busy", 64'(bus0.busy), 64'd1);
    reset = 1'b0;
    #1;
    check("mid_rst_busy", 64'(bus0.busy), 64'd0);
    check("mid_rst_mdr", 64'(bus0.BusMuxInMDR), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    load(1, 0, 32'h0000_0010);
    runAccess(1, 0, 0);
    check("rst_ram_kept0", 64'(bus0.BusMuxInMDR), 64'hCAFE_F00D);
    check("rst_ram_kept1", 64'(bus1.BusMuxInMDR), 64'hCAFE_F00D);

    // clear aborts a write in flight
    load(1, 0, 32'h0000_0020);
    load(0, 1, 32'h55AA_55AA);
    runAccess(0, 1, 0);
    load(0, 1, 32'h6666_6666);
    wr = 1; start = 1;
    cyc();
    start = 0; wr = 0; clear = 1;
    cyc();
    clear = 0;
    check("clr_busy", 64'(bus0.busy), 64'd0);
    check("clr_mdr", 64'(bus0.BusMuxInMDR), 64'd0);
    n = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (bus0.done || bus1.done) n++;
    end
    check("clr_no_done", 64'(n), 64'd0);
    load(1, 0, 32'h0000_0020);
    runAccess(1, 0, 0);
    check("clr_ram_kept0", 64'(bus0.BusMuxInMDR), 64'h55AA_55AA);
    check("clr_ram_kept1", 64'(bus1.BusMuxInMDR), 64'h55AA_55AA);

    // Address beyond DEPTH on the 256-word instance
    load(1, 0, 32'h0);
    load(0, 1, 32'h1111_2222);
    runAccess(0, 1, 0);
    load(1, 1, 32'hFFFF_FF00);
    runAccess(1, 0, 0);
    check("oob_lat2", 64'(lat[2]), 64'd4);
`ifdef MEM_PORT_BOUNDS_CHECK_EN
    check("oob_err", 64'(err2), 64'd1);
    check("oob_mdr_kept", 64'(bus2.BusMuxInMDR), 64'hFFFF_FF00);
`else
    check("oob_wrap_mdr", 64'(bus2.BusMuxInMDR), 64'h1111_2222);
`endif

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_port.md
MEM_PORT -- requirements
Module: mem_port

Interface
REQ-001 The block SHALL have parameter DATA_W, default 32, meaning memory word and bus width in bits.
REQ-002 The block SHALL have parameter ADDR_W, default 9, meaning MAR width in bits.
REQ-003 The block SHALL have parameter DEPTH, default 512, meaning number of implemented words, 1..2^ADDR_W.
REQ-004 The block SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted before each access, 0..15.
REQ-005 The block SHALL have port clock, input, 1, meaning the single rising-edge clock.
REQ-006 The block SHALL have port reset, input, 1, meaning asynchronous active-low reset.
REQ-007 The block SHALL have port clear, input, 1, meaning synchronous clear of MAR, MDR and FSM, active-high.
REQ-008 The block SHALL have port BusMuxOut, input, DATA_W, meaning the bus value.
REQ-009 The block SHALL have port MARin, input, 1, meaning load MAR from BusMuxOut[ADDR_W-1:0].
REQ-010 The block SHALL have port MDRin, input, 1, meaning load MDR from BusMuxOut.
REQ-011 The block SHALL have ports read and write, input, 1 each, meaning the access type sampled with start.
REQ-012 The block SHALL have port start, input, 1, meaning request a memory access using the current MAR.
REQ-013 The block SHALL have port BusMuxInMDR, output, DATA_W, meaning the current MDR contents.
REQ-014 The block SHALL have ports busy and done, output, 1 each, meaning access in progress and one-cycle completion pulse.
REQ-015 The block SHALL have port err, output, 1, meaning access fault, present only under MEM_PORT_BOUNDS_CHECK_EN.

Function
REQ-016 The FSM SHALL use states IDLE, WAIT, ACCESS and DONE.
REQ-017 In IDLE, start with exactly one of read/write SHALL latch the type and go to WAIT, or to ACCESS if WAIT_CYCLES=0.
REQ-018 WAIT SHALL count WAIT_CYCLES clocks and then go to ACCESS.
REQ-019 ACCESS SHALL last one clock and then go to DONE; DONE SHALL last one clock and then return to IDLE.
REQ-020 A read in ACCESS SHALL load MDR with RAM[MAR], visible on BusMuxInMDR in DONE; latency start-to-done SHALL be WAIT_CYCLES+2 clocks.
REQ-021 A write in ACCESS SHALL store MDR into RAM[MAR].
REQ-022 done SHALL be high only in DONE; busy SHALL be high in WAIT, ACCESS and DONE.
REQ-023 start while busy SHALL be ignored, with no queueing.
REQ-024 start with read and write both high, or both low, SHALL be ignored and the FSM SHALL stay in IDLE.
REQ-025 While busy, MARin and MDRin SHALL be ignored, freezing the address and data of the access in flight.
REQ-026 In IDLE, simultaneous MARin and MDRin SHALL load both registers from BusMuxOut in the same clock.
REQ-027 MAR SHALL keep only the low ADDR_W bits of BusMuxOut; MDR SHALL take all DATA_W bits.
REQ-028 clear SHALL take priority over all other inputs and abort any access in flight without a RAM write and without a done pulse.
REQ-029 RAM contents SHALL NOT be affected by reset or clear.

Reset
REQ-030 When reset is low, MAR, MDR, the wait counter and err SHALL become 0 and the FSM SHALL go to IDLE immediately, independent of clock.
REQ-031 When reset is low, busy and done SHALL be 0.
REQ-032 Reset asserted mid-access SHALL abort the access; a write not yet in ACCESS SHALL NOT occur.
REQ-033 The first start SHALL be accepted on the first rising edge after reset deasserts.

Configuration
REQ-034 With MEM_PORT_BOUNDS_CHECK_EN defined, an access with MAR >= DEPTH SHALL suppress the RAM read/write, leave MDR unchanged, and still complete with done.
REQ-035 With MEM_PORT_BOUNDS_CHECK_EN defined, err SHALL be 1 in DONE for such a faulted access and 0 otherwise.
REQ-036 Without MEM_PORT_BOUNDS_CHECK_EN, the err port SHALL be absent and addresses SHALL be used modulo DEPTH.

Verification
REQ-037 The bench SHALL cover write then read at default parameters: MAR=0x005, MDR=0xDEADBEEF, write start, then MDRin=0, read start -> done 4 clocks after each start, BusMuxInMDR=0xDEADBEEF.
REQ-038 The bench SHALL cover WAIT_CYCLES=0: read start -> done exactly 2 clocks later, busy high for 2 clocks.
REQ-039 The bench SHALL cover start pulsed in WAIT, and MARin=0x1FF in WAIT -> ignored, with a single done and the original address used.
REQ-040 The bench SHALL cover read=write=1 with start -> busy stays 0, no done, RAM unchanged.
REQ-041 The bench SHALL cover reset low during WAIT of a write to 0x010 -> busy=0 and MDR=0 immediately, and RAM[0x010] keeps its old value.
REQ-042 The bench SHALL cover DEPTH=256 with MEM_PORT_BOUNDS_CHECK_EN and a read at MAR=0x100 -> done with err=1 and MDR unchanged.
